// File: rtl/adc_osr_accumulator.sv
// Oversampling accumulator behind the 12-bit SAR ADC: sums 1/4/16/64/256 samples
// and emits a left-aligned 16-bit result plus a completion strobe.
module adc_osr_accumulator (
    input  logic        data_valid_strobe,
    input  logic        rst_n,
    input  logic [2:0]  osr_mode_in,
    input  logic [11:0] data_in,
    output logic [15:0] data_out,
    output logic        conversion_finished_strobe_out
);

    logic [19:0] acc;
    logic [7:0]  cnt;
    logic [2:0]  mode_q;

    logic [2:0]  mode_eff;
    logic [7:0]  cnt_last;
    logic [19:0] sum;
    logic [15:0] norm;

    // Mode is only sampled at a conversion boundary; codes 5-7 fold to mode 0.
    always_comb begin
        mode_eff = (cnt == 8'd0) ? osr_mode_in : mode_q;
        if (mode_eff > 3'd4)
            mode_eff = 3'd0;
    end

    assign sum = acc + {8'd0, data_in};

    always_comb begin
        cnt_last = 8'd0;
        norm     = {sum[11:0], 4'b0000};
        case (mode_eff)
            3'd1: begin cnt_last = 8'd3;   norm = {sum[13:0], 2'b00}; end
            3'd2: begin cnt_last = 8'd15;  norm = sum[15:0];          end
            3'd3: begin cnt_last = 8'd63;  norm = sum[17:2];          end
            3'd4: begin cnt_last = 8'd255; norm = sum[19:4];          end
            default: begin cnt_last = 8'd0; norm = {sum[11:0], 4'b0000}; end
        endcase
    end

    always_ff @(posedge data_valid_strobe or negedge rst_n) begin
        if (!rst_n) begin
            acc                            <= '0;
            cnt                            <= '0;
            mode_q                         <= '0;
            data_out                       <= '0;
            conversion_finished_strobe_out <= 1'b0;
        end else begin
            if (cnt == 8'd0)
                mode_q <= mode_eff;
            if (cnt == cnt_last) begin
                data_out                       <= norm;
                conversion_finished_strobe_out <= 1'b1;
                acc                            <= '0;
                cnt                            <= '0;
            end else begin
                acc                            <= sum;
                cnt                            <= cnt + 8'd1;
                conversion_finished_strobe_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_osr_accumulator.sv
// Directed bench for adc_osr_accumulator with hand-computed expected results.
module tb_adc_osr_accumulator;

    logic        clk;
    logic        rst_n;
    logic [2:0]  osr_mode_in;
    logic [11:0] data_in;
    logic [15:0] data_out;
    logic        strobe;

    int n_pass  = 0;
    int n_total = 0;

    adc_osr_accumulator dut (
        .data_valid_strobe              (clk),
        .rst_n                          (rst_n),
        .osr_mode_in                    (osr_mode_in),
        .data_in                        (data_in),
        .data_out                       (data_out),
        .conversion_finished_strobe_out (strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one sample and observe outputs 1 time unit after the capturing edge.
    task automatic step(input logic [11:0] d);
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #12;
        n_total++;
        if (data_out !== 16'h0000 || strobe !== 1'b0)
            $display("FAIL reset_init: data_out=%h strobe=%b want 0000/0", data_out, strobe);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        osr_mode_in = 3'd0;
        step(12'h123);
        n_total++;
        if (data_out !== 16'h1230 || strobe !== 1'b1)
            $display("FAIL reset_pre: data_out=%h strobe=%b want 1230/1", data_out, strobe);
        else n_pass++;
        osr_mode_in = 3'd3;
        for (int i = 0; i < 10; i++) step(12'hFFF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++;
        if (data_out !== 16'h0000 || strobe !== 1'b0)
            $display("FAIL reset_mid: data_out=%h strobe=%b want 0000/0", data_out, strobe);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) step(12'(i));
        n_total++;
        if (data_out !== 16'h01F8 || strobe !== 1'b1)
            $display("FAIL reset_after: data_out=%h strobe=%b want 01F8/1", data_out, strobe);
        else n_pass++;
    endtask

    task automatic test_mode0;
        logic [11:0] d [3] = '{12'h111, 12'h222, 12'h123};
        logic [15:0] e [3] = '{16'h1110, 16'h2220, 16'h1230};
        osr_mode_in = 3'd0;
        for (int i = 0; i < 3; i++) begin
            step(d[i]);
            n_total++;
            if (data_out !== e[i] || strobe !== 1'b1)
                $display("FAIL mode0_%0d: data_out=%h strobe=%b want %h/1", i, data_out, strobe, e[i]);
            else n_pass++;
        end
        osr_mode_in = 3'd5;
        step(12'hABC);
        n_total++;
        if (data_out !== 16'hABC0 || strobe !== 1'b1)
            $display("FAIL mode5_as_0: data_out=%h strobe=%b want ABC0/1", data_out, strobe);
        else n_pass++;
    endtask

    task automatic test_mode1;
        logic [7:0]  sb_seen;
        osr_mode_in = 3'd1;
        sb_seen = '0;
        for (int i = 0; i < 8; i++) begin
            step(12'(i));
            sb_seen[i] = strobe;
            if (i == 3) begin
                n_total++;
                if (data_out !== 16'h0018)
                    $display("FAIL mode1_a: data_out=%h want 0018", data_out);
                else n_pass++;
            end
        end
        n_total++;
        if (data_out !== 16'h0058)
            $display("FAIL mode1_b: data_out=%h want 0058", data_out);
        else n_pass++;
        n_total++;
        if (sb_seen !== 8'b1000_1000)
            $display("FAIL mode1_strobe: pattern=%b want 10001000", sb_seen);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int n_sb;
        osr_mode_in = 3'd2;
        for (int i = 0; i < 16; i++) step(12'h890);
        n_total++;
        if (data_out !== 16'h8900 || strobe !== 1'b1)
            $display("FAIL mode2_const: data_out=%h strobe=%b want 8900/1", data_out, strobe);
        else n_pass++;
        n_sb = 0;
        for (int i = 0; i < 16; i++) begin
            step(12'h890 + 12'(i));
            if (strobe) n_sb++;
        end
        n_total++;
        if (data_out !== 16'h8978 || strobe !== 1'b1)
            $display("FAIL mode2_ramp: data_out=%h strobe=%b want 8978/1", data_out, strobe);
        else n_pass++;
        n_total++;
        if (n_sb !== 1)
            $display("FAIL mode2_strobe_count: got %0d want 1", n_sb);
        else n_pass++;
    endtask

    task automatic test_mode3_4;
        osr_mode_in = 3'd3;
        for (int i = 0; i < 64; i++) step(12'(i));
        n_total++;
        if (data_out !== 16'h01F8 || strobe !== 1'b1)
            $display("FAIL mode3_ramp: data_out=%h strobe=%b want 01F8/1", data_out, strobe);
        else n_pass++;
        osr_mode_in = 3'd4;
        for (int i = 0; i < 255; i++) step(12'(i));
        n_total++;
        if (strobe !== 1'b0)
            $display("FAIL mode4_early: strobe=%b want 0 before 256th sample", strobe);
        else n_pass++;
        step(12'd255);
        n_total++;
        if (data_out !== 16'h07F8 || strobe !== 1'b1)
            $display("FAIL mode4_ramp: data_out=%h strobe=%b want 07F8/1", data_out, strobe);
        else n_pass++;
        for (int i = 0; i < 256; i++) step(12'hFFF);
        n_total++;
        if (data_out !== 16'hFFF0 || strobe !== 1'b1)
            $display("FAIL mode4_fullscale: data_out=%h strobe=%b want FFF0/1", data_out, strobe);
        else n_pass++;
    endtask

    task automatic test_mode_change;
        osr_mode_in = 3'd2;
        for (int i = 0; i < 5; i++) step(12'h100);
        osr_mode_in = 3'd1;
        for (int i = 0; i < 10; i++) step(12'h100);
        n_total++;
        if (strobe !== 1'b0)
            $display("FAIL modechg_early: strobe=%b want 0 after 15 samples", strobe);
        else n_pass++;
        step(12'h100);
        n_total++;
        if (data_out !== 16'h1000 || strobe !== 1'b1)
            $display("FAIL modechg_old: data_out=%h strobe=%b want 1000/1", data_out, strobe);
        else n_pass++;
        for (int i = 0; i < 4; i++) step(12'h010);
        n_total++;
        if (data_out !== 16'h0100 || strobe !== 1'b1)
            $display("FAIL modechg_new: data_out=%h strobe=%b want 0100/1", data_out, strobe);
        else n_pass++;
    endtask

    initial begin
        rst_n       = 1'b0;
        osr_mode_in = 3'd0;
        data_in     = '0;
        test_reset;
        test_mode0;
        test_mode1;
        test_back_to_back;
        test_mode3_4;
        test_mode_change;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/adc_osr_accumulator.md
# adc_osr_accumulator

Oversampling accumulator placed directly after the 12-bit SAR ADC core. It sums 1, 4, 16, 64 or 256 consecutive conversion results, selected by a mode input. It presents each sum normalised to a 16-bit, left-aligned word and pulses a one-cycle completion flag. Its only clock is the ADC's data-valid strobe, so one clock edge corresponds to one sample.

## Interface
- No parameters; all widths fixed (12-bit input, 16-bit output, 20-bit accumulator, 8-bit sample counter).
- Clocking and reset: one clock; reset is asynchronous and active-low. Clock port `data_valid_strobe`, reset port `rst_n`.
- data_valid_strobe  input  1  clock; each rising edge captures one ADC sample from data_in.
- rst_n  input  1  asynchronous active-low reset.
- osr_mode_in  input  3  oversampling ratio: 0→1, 1→4, 2→16, 3→64, 4→256 samples; codes 5–7 behave as 0.
- data_in  input  12  unsigned ADC sample, stable around the rising edge.
- data_out  output  16  last completed, normalised result (registered).
- conversion_finished_strobe_out  output  1  high for the clock period following each completed result.

## Operation
- State per clock: accumulator acc[19:0], sample counter cnt[7:0], latched mode mode_q[2:0].
- Mode latching: when cnt==0, the effective mode is osr_mode_in and it is stored into mode_q. When cnt!=0, the effective mode is mode_q. A mode change mid-conversion therefore takes effect at the next conversion boundary.
- N = number of samples for the effective mode; sum = acc + data_in (20-bit, unsigned, never overflows).
- Each rising edge when cnt == N−1 completes a conversion:
  - data_out <= normalise(sum);
  - conversion_finished_strobe_out <= 1;
  - acc <= 0; cnt <= 0.
- Each other rising edge accumulates:
  - acc <= sum; cnt <= cnt+1;
  - conversion_finished_strobe_out <= 0;
  - data_out holds its value.
- Normalisation to 16 bits:
  - mode 0: sum[11:0]<<4
  - mode 1: sum[13:0]<<2
  - mode 2: sum[15:0]
  - mode 3: sum[17:2]
  - mode 4: sum[19:4]
  - Right shifts truncate (no rounding).
- Mode 0: every edge completes a conversion, so the strobe stays high continuously and data_out follows data_in<<4 with one edge of latency.

## Timing
- Reset (rst_n low, asynchronous, any time): acc=0, cnt=0, mode_q=0, data_out=16'h0000, conversion_finished_strobe_out=0. A partial accumulation is discarded.
- After reset release, the first rising edge is sample 1 of a new conversion.
- Latency: data_out and the strobe update on the same rising edge that captures the Nth sample, and are both valid until the next edge.
- The strobe is one data_valid_strobe period wide, except in mode 0 where it is continuous.
- Conversions run back-to-back with no idle sample: sample N+1 starts the next conversion.
- Outputs are glitch-free registers; no combinational path from inputs to outputs.

## Test plan
- Reset check: assert rst_n mid-conversion (mode 3, after 10 samples) → data_out=0000, strobe=0 immediately. After release, 64 samples of 0..63 → data_out=01F8.
- Mode 0 passthrough: data 111 then 222, then 123 → data_out 1110, 2220, 1230 one edge later; strobe high every cycle.
- Mode 1: samples 0,1,2,3 → data_out=0018, strobe high for exactly one period after the 4th edge.
- Mode 2: 16×890 → 8900. Then back-to-back 16 samples 890+i (i=0..15) → 8978, with exactly one strobe per conversion.
- Mode 3/4: 64 samples i=0..63 → 01F8. 256 samples i=0..255 → 07F8. Full-scale 256×FFF → FFF0 with no overflow.
- Mode change mid-conversion: switch osr_mode_in from 2 to 1 after 5 samples → the current conversion still completes after 16 samples with mode-2 scaling; the next conversion uses 4 samples.
